// File: rtl/apb_arb_pkg.sv
`default_nettype none
// ============================================================================
// Module      : apb_arb_pkg
// Description : Shared types and helpers for the APB read/write burst arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
package apb_arb_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        BURST   = 2'd1,
        RELEASE = 2'd2
    } arb_state_t;

    typedef enum logic {
        GRANT_WR = 1'b0,
        GRANT_RD = 1'b1
    } arb_grant_t;

    // Bits needed to hold 0..value-1, never less than one.
    function automatic int clog2(input int value);
        int w;
        w = 1;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < value) begin
                w = i + 1;
            end
        end
        return w;
    endfunction

endpackage
`default_nettype wire

// File: rtl/apb_arb_watchdog.sv
`default_nettype none
// ============================================================================
// Module      : apb_arb_watchdog
// Description : Per-beat stall counter; flags expiry when a beat overruns.
// Revision    : 1.0 - initial release
// ============================================================================
module apb_arb_watchdog
    import apb_arb_pkg::*;
#(
    parameter int TIMEOUT = 256
) (
    input  logic clk,
    input  logic rst,
    input  logic i_clear,
    input  logic i_enable,
    output logic o_expire
);

    localparam int                 c_cnt_w = clog2(TIMEOUT);
    // Expiry fires on the edge that takes the count to TIMEOUT-1.
    localparam logic [c_cnt_w-1:0] c_limit = c_cnt_w'(TIMEOUT - 2);

    logic [c_cnt_w-1:0] r_cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (i_clear) begin
            r_cnt <= '0;
        end else if (i_enable) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    assign o_expire = i_enable && !i_clear && (r_cnt == c_limit);

endmodule
`default_nettype wire

// File: rtl/apb_rw_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : apb_rw_arbiter
// Description : Round-robin burst arbiter sharing one APB engine between the
//               AXI write and read paths, with a per-beat watchdog.
// Revision    : 1.0 - initial release
// ============================================================================
module apb_rw_arbiter
    import apb_arb_pkg::*;
#(
    parameter int LEN_W   = 8,
    parameter int TIMEOUT = 256
) (
    input  logic             ACLK,
    input  logic             RESET,
    input  logic             WR_REQ,
    input  logic [LEN_W-1:0] WR_LEN,
    input  logic             RD_REQ,
    input  logic [LEN_W-1:0] RD_LEN,
    input  logic             BEAT_DONE,
    output logic             GNT_WR,
    output logic             GNT_RD,
    output logic [LEN_W-1:0] BEATS_LEFT,
    output logic             LAST_BEAT,
    output logic             BURST_DONE,
    output logic             TIMEOUT_ERR
);

    arb_state_t       r_state,       w_state_nxt;
    arb_grant_t       r_last_grant,  w_last_grant_nxt;
    arb_grant_t       r_owner,       w_owner_nxt;
    logic             r_gnt_wr,      w_gnt_wr_nxt;
    logic             r_gnt_rd,      w_gnt_rd_nxt;
    logic [LEN_W-1:0] r_beats_left,  w_beats_left_nxt;
    logic             r_last_beat,   w_last_beat_nxt;
    logic             r_burst_done,  w_burst_done_nxt;
    logic             r_timeout_err, w_timeout_err_nxt;

    logic w_wr_wins;
    logic w_wd_clear;
    logic w_wd_enable;
    logic w_wd_expire;

    assign w_wd_enable = (r_state == BURST);
    assign w_wd_clear  = (r_state != BURST) || BEAT_DONE;

    apb_arb_watchdog #(
        .TIMEOUT (TIMEOUT)
    ) u_watchdog (
        .clk      (ACLK),
        .rst      (RESET),
        .i_clear  (w_wd_clear),
        .i_enable (w_wd_enable),
        .o_expire (w_wd_expire)
    );

    // Write wins when alone, or when contested and read was served last.
    assign w_wr_wins = WR_REQ && (!RD_REQ || (r_last_grant == GRANT_RD));

    always_ff @(posedge ACLK or posedge RESET) begin
        if (RESET) begin
            r_state       <= IDLE;
            r_last_grant  <= GRANT_RD;
            r_owner       <= GRANT_RD;
            r_gnt_wr      <= 1'b0;
            r_gnt_rd      <= 1'b0;
            r_beats_left  <= '0;
            r_last_beat   <= 1'b0;
            r_burst_done  <= 1'b0;
            r_timeout_err <= 1'b0;
        end else begin
            r_state       <= w_state_nxt;
            r_last_grant  <= w_last_grant_nxt;
            r_owner       <= w_owner_nxt;
            r_gnt_wr      <= w_gnt_wr_nxt;
            r_gnt_rd      <= w_gnt_rd_nxt;
            r_beats_left  <= w_beats_left_nxt;
            r_last_beat   <= w_last_beat_nxt;
            r_burst_done  <= w_burst_done_nxt;
            r_timeout_err <= w_timeout_err_nxt;
        end
    end

    always_comb begin
        w_state_nxt       = r_state;
        w_last_grant_nxt  = r_last_grant;
        w_owner_nxt       = r_owner;
        w_gnt_wr_nxt      = r_gnt_wr;
        w_gnt_rd_nxt      = r_gnt_rd;
        w_beats_left_nxt  = r_beats_left;
        w_last_beat_nxt   = r_last_beat;
        w_burst_done_nxt  = 1'b0;
        w_timeout_err_nxt = 1'b0;

        case (r_state)
            IDLE: begin
                if (WR_REQ || RD_REQ) begin
                    w_state_nxt = BURST;
                    if (w_wr_wins) begin
                        w_owner_nxt      = GRANT_WR;
                        w_gnt_wr_nxt     = 1'b1;
                        w_beats_left_nxt = WR_LEN;
                        w_last_beat_nxt  = (WR_LEN == '0);
                    end else begin
                        w_owner_nxt      = GRANT_RD;
                        w_gnt_rd_nxt     = 1'b1;
                        w_beats_left_nxt = RD_LEN;
                        w_last_beat_nxt  = (RD_LEN == '0);
                    end
                end
            end

            BURST: begin
                // A beat landing on the expiry cycle takes priority over the abort.
                if (BEAT_DONE) begin
                    if (r_beats_left == '0) begin
                        w_state_nxt      = RELEASE;
                        w_gnt_wr_nxt     = 1'b0;
                        w_gnt_rd_nxt     = 1'b0;
                        w_last_beat_nxt  = 1'b0;
                        w_burst_done_nxt = 1'b1;
                    end else begin
                        w_beats_left_nxt = r_beats_left - 1'b1;
                        w_last_beat_nxt  = (r_beats_left == LEN_W'(1));
                    end
                end else if (w_wd_expire) begin
                    w_state_nxt       = RELEASE;
                    w_gnt_wr_nxt      = 1'b0;
                    w_gnt_rd_nxt      = 1'b0;
                    w_beats_left_nxt  = '0;
                    w_last_beat_nxt   = 1'b0;
                    w_timeout_err_nxt = 1'b1;
                end
            end

            RELEASE: begin
                w_last_grant_nxt = r_owner;
                w_state_nxt      = IDLE;
            end

            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    assign GNT_WR      = r_gnt_wr;
    assign GNT_RD      = r_gnt_rd;
    assign BEATS_LEFT  = r_beats_left;
    assign LAST_BEAT   = r_last_beat;
    assign BURST_DONE  = r_burst_done;
    assign TIMEOUT_ERR = r_timeout_err;

endmodule
`default_nettype wire

// File: tb/tb_apb_rw_arbiter.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : tb_apb_rw_arbiter
// Description : Scoreboard bench for apb_rw_arbiter with directed bursts.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_apb_rw_arbiter;

    localparam int LEN_W   = 8;
    localparam int TIMEOUT = 8;

    localparam int EV_GNT  = 0;
    localparam int EV_BEAT = 1;
    localparam int EV_DONE = 2;
    localparam int EV_TMO  = 3;

    localparam int P_WR    = 0;
    localparam int P_RD    = 1;
    localparam int P_NONE  = 2;

    logic             ACLK      = 1'b0;
    logic             RESET     = 1'b1;
    logic             WR_REQ    = 1'b0;
    logic [LEN_W-1:0] WR_LEN    = '0;
    logic             RD_REQ    = 1'b0;
    logic [LEN_W-1:0] RD_LEN    = '0;
    logic             BEAT_DONE = 1'b0;
    logic             GNT_WR;
    logic             GNT_RD;
    logic [LEN_W-1:0] BEATS_LEFT;
    logic             LAST_BEAT;
    logic             BURST_DONE;
    logic             TIMEOUT_ERR;

    typedef struct {
        int kind;
        int path;
        int beats;
        int last;
        int cyc;
    } ev_t;

    ev_t q[$];

    int n_tests    = 0;
    int n_fail     = 0;
    int cyc        = 0;
    int model_left = 0;
    int model_path = P_NONE;

    logic             p_wr    = 1'b0;
    logic             p_rd    = 1'b0;
    logic [LEN_W-1:0] p_beats = '0;

    apb_rw_arbiter #(
        .LEN_W   (LEN_W),
        .TIMEOUT (TIMEOUT)
    ) dut (
        .ACLK        (ACLK),
        .RESET       (RESET),
        .WR_REQ      (WR_REQ),
        .WR_LEN      (WR_LEN),
        .RD_REQ      (RD_REQ),
        .RD_LEN      (RD_LEN),
        .BEAT_DONE   (BEAT_DONE),
        .GNT_WR      (GNT_WR),
        .GNT_RD      (GNT_RD),
        .BEATS_LEFT  (BEATS_LEFT),
        .LAST_BEAT   (LAST_BEAT),
        .BURST_DONE  (BURST_DONE),
        .TIMEOUT_ERR (TIMEOUT_ERR)
    );

    always #5 ACLK = ~ACLK;

    always @(posedge ACLK) cyc <= cyc + 1;

    task automatic tick();
        @(posedge ACLK);
        #1;
    endtask

    task automatic push(input int kind, input int path, input int beats, input int last, input int at);
        ev_t e;
        e.kind  = kind;
        e.path  = path;
        e.beats = beats;
        e.last  = last;
        e.cyc   = at;
        q.push_back(e);
    endtask

    task automatic check(input string name, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic observe(input int kind, input int path, input int beats, input int last);
        ev_t e;
        n_tests++;
        if (q.size() == 0) begin
            n_fail++;
            $display("FAIL unexpected_event: got kind=%0d path=%0d beats=%0d at cycle %0d, expected no event",
                     kind, path, beats, cyc);
        end else begin
            e = q.pop_front();
            if (e.kind != kind || e.path != path || e.cyc != cyc ||
                (e.beats >= 0 && e.beats != beats) || (e.last >= 0 && e.last != last)) begin
                n_fail++;
                $display("FAIL event: got kind=%0d path=%0d beats=%0d last=%0d cyc=%0d, expected kind=%0d path=%0d beats=%0d last=%0d cyc=%0d",
                         kind, path, beats, last, cyc, e.kind, e.path, e.beats, e.last, e.cyc);
            end
        end
    endtask

    // Monitor: turns DUT output activity into events and matches them in order.
    always @(negedge ACLK) begin
        int gpath;
        if (!RESET) begin
            n_tests++;
            if (GNT_WR && GNT_RD) begin
                n_fail++;
                $display("FAIL onehot_grant: got GNT_WR=1 GNT_RD=1 at cycle %0d, expected at most one", cyc);
            end
            gpath = GNT_WR ? P_WR : (GNT_RD ? P_RD : P_NONE);
            if (gpath != P_NONE && !(p_wr || p_rd))
                observe(EV_GNT, gpath, int'(BEATS_LEFT), int'(LAST_BEAT));
            else if (gpath != P_NONE && BEATS_LEFT != p_beats)
                observe(EV_BEAT, gpath, int'(BEATS_LEFT), int'(LAST_BEAT));
            if (BURST_DONE)
                observe(EV_DONE, gpath, int'(BEATS_LEFT), int'(LAST_BEAT));
            if (TIMEOUT_ERR)
                observe(EV_TMO, gpath, int'(BEATS_LEFT), int'(LAST_BEAT));
        end
        p_wr    <= GNT_WR;
        p_rd    <= GNT_RD;
        p_beats <= BEATS_LEFT;
    end

    task automatic send_beat();
        BEAT_DONE = 1'b1;
        if (model_left == 0) begin
            push(EV_DONE, P_NONE, -1, 0, cyc + 1);
        end else begin
            push(EV_BEAT, model_path, model_left - 1, (model_left == 1) ? 1 : 0, cyc + 1);
            model_left--;
        end
        tick();
        BEAT_DONE = 1'b0;
    endtask

    task automatic request(input int path, input int len);
        tick();
        if (path == P_WR) begin
            WR_REQ = 1'b1;
            WR_LEN = LEN_W'(len);
        end else begin
            RD_REQ = 1'b1;
            RD_LEN = LEN_W'(len);
        end
        push(EV_GNT, path, len, (len == 0) ? 1 : 0, cyc + 1);
        tick();
        if (path == P_WR) WR_REQ = 1'b0;
        else              RD_REQ = 1'b0;
        model_left = len;
        model_path = path;
    endtask

    task automatic run_beats(input int gap);
        int n;
        n = model_left + 1;
        for (int i = 0; i < n; i++) begin
            repeat (gap) tick();
            send_beat();
        end
    endtask

    // Both paths request single-beat bursts together; the loser waits RELEASE + IDLE.
    task automatic pair(input int first);
        int second;
        second = (first == P_WR) ? P_RD : P_WR;
        tick();
        WR_REQ = 1'b1;
        RD_REQ = 1'b1;
        WR_LEN = '0;
        RD_LEN = '0;
        push(EV_GNT, first, 0, 1, cyc + 1);
        tick();
        if (first == P_WR) WR_REQ = 1'b0;
        else               RD_REQ = 1'b0;
        model_left = 0;
        model_path = first;
        send_beat();
        push(EV_GNT, second, 0, 1, cyc + 2);
        tick();
        tick();
        if (second == P_WR) WR_REQ = 1'b0;
        else                RD_REQ = 1'b0;
        model_path = second;
        model_left = 0;
        send_beat();
        repeat (3) tick();
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_gnt_wr"},      int'(GNT_WR),      0);
        check({tag, "_gnt_rd"},      int'(GNT_RD),      0);
        check({tag, "_beats_left"},  int'(BEATS_LEFT),  0);
        check({tag, "_last_beat"},   int'(LAST_BEAT),   0);
        check({tag, "_burst_done"},  int'(BURST_DONE),  0);
        check({tag, "_timeout_err"}, int'(TIMEOUT_ERR), 0);
    endtask

    initial begin
        #100000;
        $display("FAIL global_timeout: got no end of test, expected completion");
        $fatal(1);
    end

    initial begin
        repeat (3) tick();
        check_all_zero("reset");
        RESET = 1'b0;
        tick();

        // Contested from reset: write first, then read.
        pair(P_WR);

        // Single write of four beats, one beat every three cycles.
        request(P_WR, 3);
        run_beats(2);
        repeat (3) tick();

        // Write was served last, so a contested pair now favours read.
        pair(P_RD);

        // Maximum-length read.
        request(P_RD, 255);
        run_beats(1);
        repeat (3) tick();

        // Stalled read: abort TIMEOUT-1 cycles after the grant.
        request(P_RD, 2);
        push(EV_TMO, P_NONE, -1, 0, cyc + TIMEOUT - 1);
        repeat (10) tick();
        check("tmo_gnt_rd_low", int'(GNT_RD), 0);
        check("tmo_done_low", int'(BURST_DONE), 0);

        // Beat lands exactly on the expiry cycle: no abort.
        request(P_RD, 1);
        repeat (TIMEOUT - 2) tick();
        send_beat();
        tick();
        send_beat();
        repeat (3) tick();

        // Asynchronous reset during the second beat of a write.
        request(P_WR, 5);
        tick();
        send_beat();
        tick();
        #2;
        RESET = 1'b1;
        #1;
        check_all_zero("async_reset");
        model_left = 0;
        tick();
        RESET = 1'b0;
        tick();
        request(P_RD, 0);
        send_beat();
        repeat (3) tick();

        // Stray beat while idle.
        BEAT_DONE = 1'b1;
        tick();
        BEAT_DONE = 1'b0;
        repeat (2) tick();
        check("stray_beats_left", int'(BEATS_LEFT), 0);
        check("stray_gnt_wr", int'(GNT_WR), 0);
        check("stray_gnt_rd", int'(GNT_RD), 0);

        // Request and length changes inside a burst are ignored.
        request(P_WR, 2);
        tick();
        WR_REQ = 1'b1;
        WR_LEN = 8'd9;
        RD_REQ = 1'b1;
        RD_LEN = 8'd7;
        tick();
        send_beat();
        tick();
        WR_REQ = 1'b0;
        RD_REQ = 1'b0;
        send_beat();
        tick();
        send_beat();
        repeat (5) tick();

        check("scoreboard_drained", q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/apb_rw_arbiter.md
# apb_rw_arbiter

Burst-level arbiter that shares the single APB master engine of the AXI-to-APB bridge between the write path (AW/W) and the read path (AR). It grants exactly one path at a time and holds the grant for a whole AXI burst, counting APB beats until the burst ends. Arbitration is round-robin. A per-beat watchdog aborts a burst whose APB slave stops responding. The block sits between the bridge's AXI request decode and its APB transfer FSM.

## Interface
Parameters:
- LEN_W, 8: width of burst length fields (AXI AxLEN, beats-1).
- TIMEOUT, 256: cycles allowed per beat before abort; legal range 2..65535.

Ports:
- ACLK  in  1  clock; all logic rising-edge.
- RESET  in  1  asynchronous, active-high reset.
- WR_REQ  in  1  write burst pending; held until GNT_WR.
- WR_LEN  in  LEN_W  write burst beats-1; valid with WR_REQ.
- RD_REQ  in  1  read burst pending; held until GNT_RD.
- RD_LEN  in  LEN_W  read burst beats-1; valid with RD_REQ.
- BEAT_DONE  in  1  one-cycle pulse from APB engine: one transfer completed (PENABLE & PREADY).
- GNT_WR  out  1  write path owns APB engine.
- GNT_RD  out  1  read path owns APB engine.
- BEATS_LEFT  out  LEN_W  beats remaining after the current one.
- LAST_BEAT  out  1  high while the current beat is the final one of the burst.
- BURST_DONE  out  1  one-cycle pulse: burst completed normally.
- TIMEOUT_ERR  out  1  one-cycle pulse: burst aborted by watchdog.

## Operation
- FSM states: IDLE, BURST, RELEASE.
- IDLE: if any REQ is high, select a winner, load BEATS_LEFT from its LEN, assert its GNT, then go to BURST. With no REQ, remain in IDLE.
- Selection: if only one REQ is high, it wins. If both are high, the path not granted last wins. last_grant resets to RD, so the first contested arbitration goes to WR.
- BURST: GNT stays stable. On BEAT_DONE with BEATS_LEFT≠0, decrement. On BEAT_DONE with BEATS_LEFT==0, go to RELEASE and pulse BURST_DONE.
- REQ changes or LEN changes during BURST are ignored. A BEAT_DONE seen in IDLE or RELEASE is ignored.
- Watchdog: counter cleared on entry to BURST and on each BEAT_DONE, incremented otherwise. On reaching TIMEOUT-1 without BEAT_DONE, go to RELEASE and pulse TIMEOUT_ERR; BURST_DONE stays low.
- If BEAT_DONE arrives in the same cycle the counter reaches TIMEOUT-1, BEAT_DONE wins (no error).
- RELEASE: both GNT low for exactly one cycle, last_grant is updated, then go to IDLE. This guarantees the PSEL gap between bursts.
- LEAST LEN_W arithmetic: BEATS_LEFT is unsigned LEN_W wide. LEN=0 means a single beat. LEN=2^LEN_W-1 is legal; no wrap because the block never decrements below 0.
- GNT_WR and GNT_RD are never high together (one-hot or zero).

## Timing
- All outputs are registered. Reset values: GNT_WR=0, GNT_RD=0, BEATS_LEFT=0, LAST_BEAT=0, BURST_DONE=0, TIMEOUT_ERR=0. State resets to IDLE, last_grant to RD, watchdog to 0.
- Grant latency: REQ high at rising edge k in IDLE gives GNT high after edge k (visible cycle k+1).
- BEAT_DONE sampled at edge m: BEATS_LEFT updates after m. On the final beat, GNT falls and BURST_DONE rises after m.
- Minimum burst occupancy is LEN+1 beats plus one RELEASE cycle. Back-to-back bursts are spaced by one idle-grant cycle (RELEASE), then one more cycle (IDLE) before the next GNT.
- Timeout: with no BEAT_DONE, TIMEOUT_ERR pulses TIMEOUT-1 cycles after GNT asserts (or after the last BEAT_DONE).
- Asserting RESET mid-burst drops GNT immediately (asynchronous). No completion or error pulse is generated.

## Structure
- Package apb_arb_pkg:
  - state enum {IDLE, BURST, RELEASE}
  - grant enum {GRANT_WR, GRANT_RD}
  - watchdog counter width function clog2(TIMEOUT)
- Sub-module apb_arb_watchdog: the timeout counter, with clear/enable/expire ports, parameterised by TIMEOUT. Everything else lives in apb_rw_arbiter.

## Test plan
- Single write, WR_LEN=3, BEAT_DONE every 3 cycles: GNT_WR for 4 beats, LAST_BEAT on the 4th, one BURST_DONE pulse, GNT_RD never high.
- WR_REQ and RD_REQ rise together from reset, both LEN=0: WR granted first, 1-cycle RELEASE, then RD granted. Repeat the pair: RD granted first (round-robin).
- Read LEN=255 (max): exactly 256 BEAT_DONE pulses consumed, BEATS_LEFT counts 255→0, no wrap, BURST_DONE after the 256th.
- TIMEOUT=8, grant RD, no BEAT_DONE: TIMEOUT_ERR pulses 7 cycles after GNT, no BURST_DONE, then GNT goes low. Also: BEAT_DONE coincident with expiry → no error.
- RESET asserted during beat 2 of a WR_LEN=5 burst: GNT_WR drops asynchronously, all outputs zero. After release, RD_REQ is granted normally.
- Stray BEAT_DONE in IDLE, and REQ toggling during BURST: no state change, BEATS_LEFT unaffected.
